// File: rtl/uart_ber_tester.sv
// Link exerciser: sends an incrementing byte stream as UART frames and checks the echo
// returned by the transceiver, counting mismatches, framing errors and echo timeouts.
module uart_ber_tester #(
   parameter int         CLKS_PER_BIT = 8,
   parameter int         NUM_BYTES    = 256,
   parameter logic [7:0] SEED         = 8'h00,
   parameter int         LAG          = 0,
   parameter int         TIMEOUT_BITS = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        tx_serial,
   input  logic        rx_serial,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_cnt,
   output logic [15:0] byte_cnt
);

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int               TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int               TO_W      = $clog2(TO_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_RELOAD = TO_W'(TO_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_ZERO   = TO_W'(0);
   localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
   localparam logic [15:0]      NUM_LAST  = 16'(NUM_BYTES);
   localparam logic [1:0]       LAG_IDX   = 2'(LAG);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEND  = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // receive side
   logic             rx_meta_r;
   logic             rx_sync_r;
   logic             rx_prev_r;
   logic             rx_active_r;
   logic [CNT_W-1:0] rx_clk_r;
   logic [3:0]       rx_bit_r;
   logic [7:0]       rx_shift_r;
   logic [7:0]       rx_data_r;
   logic             rx_ferr_r;
   logic             rx_valid_r;

   // transmit side and run control
   state_t           state_r;
   logic [7:0]       byte_r;
   logic [8:0]       tx_frame_r;
   logic [CNT_W-1:0] tx_clk_r;
   logic [3:0]       tx_bit_r;
   logic             tx_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [15:0]      err_r;
   logic [15:0]      bcnt_r;
   logic [TO_W-1:0]  to_r;
   logic             rx_pend_r;
   logic [1:0]       disc_r;
   logic [7:0]       hist_r [0:3];

   assign tx_serial = tx_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign err_cnt   = err_r;
   assign byte_cnt  = bcnt_r;

   // Free-running deserialiser; a start edge is confirmed half a bit later to reject glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r   <= 1'b1;
         rx_sync_r   <= 1'b1;
         rx_prev_r   <= 1'b1;
         rx_active_r <= 1'b0;
         rx_clk_r    <= CNT_ZERO;
         rx_bit_r    <= 4'd0;
         rx_shift_r  <= 8'h00;
         rx_data_r   <= 8'h00;
         rx_ferr_r   <= 1'b0;
         rx_valid_r  <= 1'b0;
      end else begin
         rx_meta_r  <= rx_serial;
         rx_sync_r  <= rx_meta_r;
         rx_prev_r  <= rx_sync_r;
         rx_valid_r <= 1'b0;
         if (!rx_active_r) begin
            if (rx_prev_r && !rx_sync_r) begin
               rx_active_r <= 1'b1;
               rx_clk_r    <= CNT_ZERO;
               rx_bit_r    <= 4'd0;
            end
         end else if (rx_clk_r == ((rx_bit_r == 4'd0) ? HALF_LAST : BIT_LAST)) begin
            rx_clk_r <= CNT_ZERO;
            if (rx_bit_r == 4'd0) begin
               if (rx_sync_r) begin
                  rx_active_r <= 1'b0;
               end else begin
                  rx_bit_r <= 4'd1;
               end
            end else if (rx_bit_r == 4'd9) begin
               rx_active_r <= 1'b0;
               rx_valid_r  <= 1'b1;
               rx_data_r   <= rx_shift_r;
               rx_ferr_r   <= !rx_sync_r;
            end else begin
               rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
               rx_bit_r   <= rx_bit_r + 4'd1;
            end
         end else begin
            rx_clk_r <= rx_clk_r + CNT_ONE;
         end
      end
   end

   // Run sequencer: send a frame, await its echo, score it, advance
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         byte_r     <= 8'h00;
         tx_frame_r <= 9'h1FF;
         tx_clk_r   <= CNT_ZERO;
         tx_bit_r   <= 4'd0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         err_r      <= 16'd0;
         bcnt_r     <= 16'd0;
         to_r       <= TO_ZERO;
         rx_pend_r  <= 1'b0;
         disc_r     <= 2'd0;
         hist_r[0]  <= 8'h00;
         hist_r[1]  <= 8'h00;
         hist_r[2]  <= 8'h00;
         hist_r[3]  <= 8'h00;
      end else begin
         case (state_r)
            S_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r    <= S_SEND;
                  err_r      <= 16'd0;
                  bcnt_r     <= 16'd0;
                  pass_r     <= 1'b0;
                  busy_r     <= 1'b1;
                  byte_r     <= SEED;
                  tx_frame_r <= {1'b1, SEED};
                  tx_r       <= 1'b0;
                  tx_clk_r   <= CNT_ZERO;
                  tx_bit_r   <= 4'd0;
                  rx_pend_r  <= 1'b0;
                  disc_r     <= LAG_IDX;
               end
            end
            S_SEND: begin
               if (tx_clk_r == BIT_LAST) begin
                  tx_clk_r <= CNT_ZERO;
                  if (tx_bit_r == 4'd9) begin
                     bcnt_r    <= bcnt_r + 16'd1;
                     hist_r[0] <= byte_r;
                     hist_r[1] <= hist_r[0];
                     hist_r[2] <= hist_r[1];
                     hist_r[3] <= hist_r[2];
                     to_r      <= TO_RELOAD;
                     state_r   <= S_WAIT;
                  end else begin
                     tx_r       <= tx_frame_r[0];
                     tx_frame_r <= {1'b1, tx_frame_r[8:1]};
                     tx_bit_r   <= tx_bit_r + 4'd1;
                  end
               end else begin
                  tx_clk_r <= tx_clk_r + CNT_ONE;
               end
            end
            S_WAIT: begin
               if (rx_pend_r) begin
                  rx_pend_r <= 1'b0;
                  state_r   <= S_CHECK;
               end else if (to_r == TO_ZERO) begin
                  err_r   <= sat_inc16(err_r);
                  state_r <= S_NEXT;
               end else begin
                  to_r <= to_r - TO_ONE;
               end
            end
            S_CHECK: begin
               // echoes of bytes sent before the run started are dropped unscored
               if (disc_r != 2'd0) begin
                  disc_r <= disc_r - 2'd1;
               end else if (rx_ferr_r || (rx_data_r != hist_r[LAG_IDX])) begin
                  err_r <= sat_inc16(err_r);
               end else begin
                  err_r <= err_r;
               end
               state_r <= S_NEXT;
            end
            S_NEXT: begin
               if (bcnt_r == NUM_LAST) begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  pass_r  <= (err_r == 16'd0);
               end else begin
                  state_r    <= S_SEND;
                  byte_r     <= byte_r + 8'd1;
                  tx_frame_r <= {1'b1, byte_r + 8'd1};
                  tx_r       <= 1'b0;
                  tx_clk_r   <= CNT_ZERO;
                  tx_bit_r   <= 4'd0;
               end
            end
            S_DONE: begin
               done_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               tx_r    <= 1'b1;
            end
         endcase
         if (rx_valid_r && (state_r != S_IDLE)) begin
            rx_pend_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_ber_tester.sv
// Bench for uart_ber_tester: a LAG=0 instance driven through a table of line faults,
// and a LAG=1 instance fed the previous frame as its echo.
module tb_uart_ber_tester;
   localparam int CPB  = 8;
   localparam int NB_A = 5;
   localparam int NB_B = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        tx_a, busy_a, done_a, pass_a;
   logic        tx_b, busy_b, done_b, pass_b;
   logic [15:0] err_a, bcnt_a, err_b, bcnt_b;
   logic        rx_mon_a = 1'b1, glitch_a = 1'b0, rx_mon_b = 1'b1;
   wire         rx_a, rx_b;
   assign rx_a = rx_mon_a & ~glitch_a;
   assign rx_b = rx_mon_b;

   uart_ber_tester #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB_A), .SEED(8'hFE), .LAG(0), .TIMEOUT_BITS(40)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .tx_serial(tx_a), .rx_serial(rx_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .byte_cnt(bcnt_a));

   uart_ber_tester #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB_B), .SEED(8'h10), .LAG(1), .TIMEOUT_BITS(40)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .tx_serial(tx_b), .rx_serial(rx_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .byte_cnt(bcnt_b));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // line-fault controls (main process) and monitor state (monitor processes)
   logic       stuck_a = 1'b0;
   int         flip_abs_a = -1, stop_abs_a = -1;
   int         frm_a = 0, pos_a = 0, bi_a = 0;
   logic       in_a = 1'b0;
   logic [7:0] sh_a = 8'h00;
   logic [7:0] got_a [64];
   int         frm_b = 0, pos_b = 0, bi_b = 0;
   logic       in_b = 1'b0;
   logic [7:0] sh_b = 8'h00, echo_b = 8'h55, prev_b = 8'h55;
   logic [7:0] got_b [16];
   logic [7:0] exp_q [$];

   // A: decode tx frames, loop them back with the requested corruption
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            in_a = 1'b0;
            rx_mon_a = 1'b1;
         end else begin
            if (!in_a && tx_a == 1'b0) begin
               in_a = 1'b1;
               pos_a = 0;
            end
            if (in_a) begin
               bi_a = pos_a / CPB;
               if (frm_a == stop_abs_a && bi_a == 9) rx_mon_a = 1'b0;
               else if (frm_a == flip_abs_a && bi_a == 4) rx_mon_a = ~tx_a;
               else rx_mon_a = tx_a;
               if (stuck_a) rx_mon_a = 1'b1;
               if ((pos_a % CPB) == CPB / 2 && bi_a >= 1 && bi_a <= 8) sh_a[bi_a-1] = tx_a;
               pos_a++;
               if (pos_a == 10 * CPB) begin
                  got_a[frm_a % 64] = sh_a;
                  frm_a++;
                  in_a = 1'b0;
               end
            end else begin
               rx_mon_a = stuck_a ? 1'b1 : tx_a;
            end
         end
      end
   end

   // B: echo the previous frame (8'h55 first) aligned with each new tx frame
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            in_b = 1'b0;
            rx_mon_b = 1'b1;
         end else begin
            if (!in_b && tx_b == 1'b0) begin
               in_b = 1'b1;
               pos_b = 0;
               echo_b = prev_b;
            end
            if (in_b) begin
               bi_b = pos_b / CPB;
               if (bi_b == 0) rx_mon_b = 1'b0;
               else if (bi_b == 9) rx_mon_b = 1'b1;
               else rx_mon_b = echo_b[bi_b-1];
               if ((pos_b % CPB) == CPB / 2 && bi_b >= 1 && bi_b <= 8) sh_b[bi_b-1] = tx_b;
               pos_b++;
               if (pos_b == 10 * CPB) begin
                  got_b[frm_b % 16] = sh_b;
                  prev_b = sh_b;
                  frm_b++;
                  in_b = 1'b0;
               end
            end else begin
               rx_mon_b = 1'b1;
               if (!busy_b) prev_b = 8'h55;
            end
         end
      end
   end

   typedef struct {
      logic        stuck;
      int          flip_rel;
      int          stop_rel;
      logic        restart;
      logic [15:0] exp_err;
      logic        exp_pass;
   } vec_t;
   vec_t vecs [4];

   task automatic run_a(input int idx, input vec_t v);
      int   base;
      logic seen;
      base       = frm_a;
      stuck_a    = v.stuck;
      flip_abs_a = (v.flip_rel < 0) ? -1 : base + v.flip_rel;
      stop_abs_a = (v.stop_rel < 0) ? -1 : base + v.stop_rel;
      for (int i = 0; i < NB_A; i++) exp_q.push_back(8'hFE + 8'(i));
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6000 && !seen; c++) begin
         @(negedge clk);
         start_a = (v.restart && c == 150);
         if (done_a) seen = 1'b1;
      end
      start_a = 1'b0;
      check($sformatf("v%0d_done", idx), seen, 1'b1);
      check($sformatf("v%0d_err", idx), err_a, v.exp_err);
      check($sformatf("v%0d_pass", idx), pass_a, v.exp_pass);
      check($sformatf("v%0d_bytecnt", idx), bcnt_a, 16'(NB_A));
      check($sformatf("v%0d_busy", idx), busy_a, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", idx), done_a, 1'b0);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_frames", idx), frm_a - base, NB_A);
      for (int i = 0; i < NB_A; i++)
         check($sformatf("v%0d_txbyte%0d", idx, i), got_a[(base + i) % 64], exp_q.pop_front());
      stuck_a    = 1'b0;
      flip_abs_a = -1;
      stop_abs_a = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      logic seen;
      vecs[0] = '{1'b0, -1, -1, 1'b1, 16'd0, 1'b1};
      vecs[1] = '{1'b1, -1, -1, 1'b0, 16'd5, 1'b0};
      vecs[2] = '{1'b0,  1, -1, 1'b0, 16'd1, 1'b0};
      vecs[3] = '{1'b0,  1,  3, 1'b0, 16'd2, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_tx", tx_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_pass", pass_a, 1'b0);
      check("rst_err", err_a, 16'd0);
      check("rst_bytecnt", bcnt_a, 16'd0);

      // idle-line glitch just before a run, then reset in the middle of the 2nd frame
      @(negedge clk) glitch_a = 1'b1;
      repeat (2) @(negedge clk);
      glitch_a = 1'b0;
      repeat (2) @(negedge clk);
      base = frm_a;
      for (int i = 0; i < NB_A; i++) exp_q.push_back(8'hFE + 8'(i));
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         if (frm_a == base + 1) seen = 1'b1;
      end
      check("t5_frame0_seen", seen, 1'b1);
      repeat (40) @(negedge clk);
      check("t5_glitch_err", err_a, 16'd0);
      check("t5_busy_mid", busy_a, 1'b1);
      check("t5_bytecnt_mid", bcnt_a, 16'd1);
      check("t5_txbyte0", got_a[base % 64], exp_q.pop_front());
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_tx", tx_a, 1'b1);
      check("t5_rst_busy", busy_a, 1'b0);
      check("t5_rst_err", err_a, 16'd0);
      check("t5_rst_bytecnt", bcnt_a, 16'd0);
      @(negedge clk) rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int k = 0; k < 4; k++) begin
         run_a(k, vecs[k]);
         repeat (5) @(negedge clk);
      end

      // LAG=1 run on the second instance
      base = frm_b;
      for (int i = 0; i < NB_B; i++) exp_q.push_back(8'h10 + 8'(i));
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6000 && !seen; c++) begin
         @(negedge clk);
         if (done_b) seen = 1'b1;
      end
      check("lag_done", seen, 1'b1);
      check("lag_err", err_b, 16'd0);
      check("lag_pass", pass_b, 1'b1);
      check("lag_bytecnt", bcnt_b, 16'(NB_B));
      repeat (2) @(negedge clk);
      check("lag_frames", frm_b - base, NB_B);
      for (int i = 0; i < NB_B; i++)
         check($sformatf("lag_txbyte%0d", i), got_b[(base + i) % 16], exp_q.pop_front());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
